// File: rtl/mont_exp_ctrl_pkg.sv
// Shared definitions for the Montgomery exponentiation controller.
//   DefaultWidth : default operand/modulus width in bits (R = 2^WIDTH)
//   DefaultLenW  : default width of the exponent-length field (holds 0..WIDTH)
//   state_e      : controller state encoding
package mont_exp_ctrl_pkg;

  localparam int unsigned DefaultWidth = 1024;
  localparam int unsigned DefaultLenW  = 11;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StToMont   = 3'd1,
    StSquare   = 3'd2,
    StMult     = 3'd3,
    StFromMont = 3'd4,
    StFinish   = 3'd5
  } state_e;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Montgomery exponentiation controller: computes X^E mod M by left-to-right
// square-and-multiply, issuing each Montgomery product on an external
// multiplier through a start/done handshake.
//
// Ports:
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   start                 one-cycle request, only honoured while idle
//   in_x, in_e, in_e_len  message, exponent and number of exponent bits to process
//   in_m, in_r, in_r2     odd modulus, R mod M, R^2 mod M
//   result, done, busy    X^E mod M, one-cycle completion pulse, operation in flight
//   mont_start            one-cycle issue pulse to the multiplier
//   mont_a, mont_b        registered multiplier operands, stable until mont_done
//   mont_m                captured modulus for the multiplier
//   mont_result, mont_done  multiplier product and its one-cycle valid strobe
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned LEN_W = DefaultLenW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0] in_e_len,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_r2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mont_start,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  output logic [WIDTH-1:0] mont_m,
  input  logic [WIDTH-1:0] mont_result,
  input  logic             mont_done
);

  state_e           state;
  logic [WIDTH-1:0] acc;       // running value in Montgomery domain
  logic [WIDTH-1:0] xt;        // X in Montgomery domain
  logic [WIDTH-1:0] e_q;
  logic [LEN_W-1:0] idx;       // exponent bit currently being processed
  logic             len_zero;

  logic op_done;
  logic e_bit;
  logic last_bit;

  // The issue cycle is the one with mont_start high; a done strobe there cannot
  // belong to the operation just issued, so only the wait phase accepts it.
  assign op_done  = mont_done & ~mont_start;
  assign e_bit    = |(e_q & (WIDTH'(1) << idx));
  assign last_bit = (idx == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= StIdle;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
      acc        <= '0;
      xt         <= '0;
      e_q        <= '0;
      idx        <= '0;
      len_zero   <= 1'b0;
    end else begin
      mont_start <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            // Issue the to-Montgomery conversion straight away: X * R^2 * R^-1 = X*R.
            state      <= StToMont;
            busy       <= 1'b1;
            mont_start <= 1'b1;
            mont_a     <= in_x;
            mont_b     <= in_r2;
            mont_m     <= in_m;
            acc        <= in_r;
            e_q        <= in_e;
            idx        <= in_e_len - LEN_W'(1);
            len_zero   <= (in_e_len == '0);
          end
        end

        StToMont: begin
          if (op_done) begin
            xt         <= mont_result;
            mont_start <= 1'b1;
            mont_a     <= acc;
            if (len_zero) begin
              state  <= StFromMont;
              mont_b <= WIDTH'(1);
            end else begin
              state  <= StSquare;
              mont_b <= acc;
            end
          end
        end

        StSquare: begin
          if (op_done) begin
            acc        <= mont_result;
            mont_start <= 1'b1;
            mont_a     <= mont_result;
            if (e_bit) begin
              state  <= StMult;
              mont_b <= xt;
            end else if (last_bit) begin
              state  <= StFromMont;
              mont_b <= WIDTH'(1);
            end else begin
              state  <= StSquare;
              idx    <= idx - LEN_W'(1);
              mont_b <= mont_result;
            end
          end
        end

        StMult: begin
          if (op_done) begin
            acc        <= mont_result;
            mont_start <= 1'b1;
            mont_a     <= mont_result;
            if (last_bit) begin
              state  <= StFromMont;
              mont_b <= WIDTH'(1);
            end else begin
              state  <= StSquare;
              idx    <= idx - LEN_W'(1);
              mont_b <= mont_result;
            end
          end
        end

        StFromMont: begin
          if (op_done) begin
            result <= mont_result;
            done   <= 1'b1;
            state  <= StFinish;
          end
        end

        StFinish: begin
          // done is high during this cycle; busy drops with the return to idle.
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
module tb_mont_exp_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned LW  = 4;
  localparam int unsigned BW  = 1024;
  localparam int unsigned BLW = 11;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act[191:0], exp[191:0]);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no event, expected one", name);
  endtask

  // Reference Montgomery product a*b*2^-n mod m (bit-serial).
  function automatic logic [BW-1:0] mont(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                         input logic [BW-1:0] m, input int n);
    logic [BW+1:0] t;
    t = '0;
    for (int i = 0; i < n; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[BW-1:0];
  endfunction

  // ---------------- small instance (WIDTH=8) ----------------
  logic          start;
  logic [W-1:0]  in_x, in_e, in_m, in_r, in_r2;
  logic [LW-1:0] in_e_len;
  logic [W-1:0]  result, mont_a, mont_b, mont_m, mont_result;
  logic          done, busy, mont_start, mont_done;
  logic          md, spur;
  assign mont_done = md | spur;

  mont_exp_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done)
  );

  int           lat;
  int           cnt;
  logic         pend;
  logic [W-1:0] pa, pb;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md <= 1'b0; pend <= 1'b0; cnt <= 0; mont_result <= '0; pa <= '0; pb <= '0;
    end else begin
      md <= 1'b0;
      if (mont_start) begin
        pend <= 1'b1; cnt <= lat; pa <= mont_a; pb <= mont_b;
      end else if (pend) begin
        if (cnt <= 1) begin
          md <= 1'b1;
          pend <= 1'b0;
          mont_result <= W'(mont(BW'(pa), BW'(pb), BW'(mont_m), int'(W)));
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  logic [W-1:0] sb_res[$];
  int           sb_pul[$];
  int           pulses = 0;
  int           last_done_cyc = 0;
  bit           have_done = 0;
  bit           chk_idle = 0;
  int           done_seen = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      pulses = 0; have_done = 0; chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("busy_after_done", BW'(busy), BW'(0));
        check("done_one_cycle", BW'(done), BW'(0));
        chk_idle = 0;
      end
      if (mont_start) begin
        pulses++;
        if (have_done) begin
          check("done_to_start_gap", BW'(cyc - last_done_cyc), BW'(1));
          have_done = 0;
        end
      end
      if (md) begin
        have_done = 1;
        last_done_cyc = cyc;
      end
      if (done) begin
        done_seen++;
        if (sb_res.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got done with result 0x%0h, expected no done", result);
        end else begin
          check("result", BW'(result), BW'(sb_res.pop_front()));
          check("start_pulses", BW'(pulses), BW'(sb_pul.pop_front()));
          check("busy_with_done", BW'(busy), BW'(1));
        end
        pulses = 0; have_done = 0; chk_idle = 1;
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] e, input logic [LW-1:0] len,
                        input logic [W-1:0] exp_res, input int exp_pul);
    @(negedge clk);
    in_x = x; in_e = e; in_e_len = len; start = 1'b1;
    sb_res.push_back(exp_res);
    sb_pul.push_back(exp_pul);
    @(negedge clk);
    start = 1'b0;
    in_x = ~x;       // inputs are free to change once accepted
    in_e = ~e;
    in_e_len = ~len;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_seen;
    k = 0;
    while (done_seen == n0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_seen == n0) begin
      fail_now("done_timeout");
      sb_res.delete(); sb_pul.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] e, input logic [LW-1:0] len,
                     input logic [W-1:0] exp_res, input int exp_pul);
    launch(x, e, len, exp_res, exp_pul);
    wait_done(3000);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- large instance (WIDTH=1024) ----------------
  logic           b_start;
  logic [BW-1:0]  b_in_x, b_in_e, b_in_m, b_in_r, b_in_r2;
  logic [BLW-1:0] b_in_e_len;
  logic [BW-1:0]  b_result, b_mont_a, b_mont_b, b_mont_m, b_mont_result;
  logic           b_done, b_busy, b_mont_start, b_mont_done;

  mont_exp_ctrl #(.WIDTH(BW), .LEN_W(BLW)) dut_big (
    .clk(clk), .resetn(resetn), .start(b_start),
    .in_x(b_in_x), .in_e(b_in_e), .in_e_len(b_in_e_len), .in_m(b_in_m), .in_r(b_in_r),
    .in_r2(b_in_r2),
    .result(b_result), .done(b_done), .busy(b_busy),
    .mont_start(b_mont_start), .mont_a(b_mont_a), .mont_b(b_mont_b), .mont_m(b_mont_m),
    .mont_result(b_mont_result), .mont_done(b_mont_done)
  );

  int            b_cnt;
  logic          b_pend;
  logic [BW-1:0] b_pa, b_pb;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b_mont_done <= 1'b0; b_pend <= 1'b0; b_cnt <= 0; b_mont_result <= '0;
      b_pa <= '0; b_pb <= '0;
    end else begin
      b_mont_done <= 1'b0;
      if (b_mont_start) begin
        b_pend <= 1'b1; b_cnt <= 5; b_pa <= b_mont_a; b_pb <= b_mont_b;
      end else if (b_pend) begin
        if (b_cnt <= 1) begin
          b_mont_done <= 1'b1;
          b_pend <= 1'b0;
          b_mont_result <= mont(b_pa, b_pb, b_mont_m, int'(BW));
        end else begin
          b_cnt <= b_cnt - 1;
        end
      end
    end
  end

  logic [BW-1:0] b_sb_res[$];
  int            b_sb_pul[$];
  int            b_pulses = 0;
  int            b_done_seen = 0;

  always @(negedge clk) begin
    if (resetn) begin
      if (b_mont_start) b_pulses++;
      if (b_done) begin
        b_done_seen++;
        if (b_sb_res.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL big_unexpected_done: got done, expected no done");
        end else begin
          check("big_result", b_result, b_sb_res.pop_front());
          check("big_start_pulses", BW'(b_pulses), BW'(b_sb_pul.pop_front()));
        end
        b_pulses = 0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    start = 1'b0; in_x = '0; in_e = '0; in_e_len = '0;
    in_m = 8'd241; in_r = 8'd15; in_r2 = 8'd225;
    lat = 5; spur = 1'b0;
    // M = 2^1024-1 makes R mod M = R^2 mod M = 1, and 2^65537 mod M = 2^(65537 mod 1024) = 2.
    b_start = 1'b0; b_in_x = BW'(2); b_in_e = BW'(32'h10001); b_in_e_len = BLW'(17);
    b_in_m = '1; b_in_r = BW'(1); b_in_r2 = BW'(1);

    repeat (3) @(negedge clk);
    check("rst_result", BW'(result), BW'(0));
    check("rst_done", BW'(done), BW'(0));
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_mont_start", BW'(mont_start), BW'(0));
    check("rst_mont_abm", BW'({mont_a, mont_b, mont_m}), BW'(0));
    check("rst_big_result", b_result, BW'(0));
    resetn = 1'b1;

    run(8'd5, 8'd3, 4'd2, 8'd125, 6);
    run(8'd2, 8'h0A, 4'd4, 8'd60, 8);
    lat = 1;
    run(8'd2, 8'h0A, 4'd4, 8'd60, 8);
    lat = 37;
    run(8'd2, 8'h0A, 4'd4, 8'd60, 8);
    lat = 5;
    run(8'd5, 8'hFF, 4'd0, 8'd1, 2);
    run(8'd5, 8'd1, 4'd1, 8'd5, 4);

    // Stray mont_done while idle.
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;

    // Stray mont_done on the issue cycle, then a start while busy.
    launch(8'd2, 8'h0A, 4'd4, 8'd60, 8);
    check("issue_after_accept", BW'(mont_start), BW'(1));
    spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    repeat (10) @(negedge clk);
    in_x = 8'd7; in_e = 8'd3; in_e_len = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(3000);
    repeat (2) @(negedge clk);

    // Reset during the third operation.
    launch(8'd2, 8'h0A, 4'd4, 8'd60, 8);
    k = 1;  // the TOMONT issue is visible at this edge
    for (int i = 0; i < 500 && k < 3; i++) begin
      @(negedge clk);
      if (mont_start) k++;
    end
    if (k < 3) fail_now("third_op_timeout");
    #2;
    resetn = 1'b0;
    sb_res.delete(); sb_pul.delete();
    #1;
    check("midrst_result", BW'(result), BW'(0));
    check("midrst_done_busy", BW'({done, busy}), BW'(0));
    check("midrst_mont_start", BW'(mont_start), BW'(0));
    check("midrst_mont_abm", BW'({mont_a, mont_b, mont_m}), BW'(0));
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run(8'd5, 8'd3, 4'd2, 8'd125, 6);

    // Wide operand run.
    @(negedge clk);
    b_sb_res.push_back(BW'(2));
    b_sb_pul.push_back(21);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_in_x = '0;
    k = 0;
    while (b_done_seen == 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    if (b_done_seen == 0) fail_now("big_done_timeout");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
Initiator side of the montgomery start/done interface. Given a message X, an exponent E and a modulus M, it sequences Montgomery multiplications to compute X^E mod M using left-to-right square-and-multiply. It issues each operation on the multiplier's start/done ports and collects each result. It sits between the RSA top level and the existing montgomery multiplier; the top level wires the two together.

Parameters:
WIDTH, 1024, operand/modulus width in bits; R = 2^WIDTH
LEN_W, 11, width of the exponent-length field; must hold values 0..WIDTH

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; sampled only in IDLE
in_x  in  WIDTH  message, < M
in_e  in  WIDTH  exponent
in_e_len  in  LEN_W  number of exponent bits processed, 0..WIDTH
in_m  in  WIDTH  odd modulus
in_r  in  WIDTH  R mod M
in_r2  in  WIDTH  R^2 mod M
result  out  WIDTH  X^E mod M, held until next accepted start
done  out  1  one-cycle pulse when result is valid
busy  out  1  high from accept until done, inclusive
mont_start  out  1  one-cycle pulse to multiplier
mont_a  out  WIDTH  multiplier operand A, registered
mont_b  out  WIDTH  multiplier operand B, registered
mont_m  out  WIDTH  multiplier modulus (captured in_m)
mont_result  in  WIDTH  multiplier result, valid when mont_done=1
mont_done  in  1  multiplier completion, sampled high for one cycle

Behaviour:
- Reset (async, resetn=0): state=IDLE; result, mont_a, mont_b, mont_m = 0; done, busy, mont_start = 0. Reset mid-operation aborts the operation; no done is produced. The multiplier shares resetn.
- IDLE:
  - Accepts start=1 on a rising edge.
  - Captures in_x, in_e, in_e_len, in_m, in_r2 and in_r into internal registers. Inputs may change freely afterwards.
  - Sets acc <= in_r and idx <= in_e_len-1.
- States: IDLE -> TOMONT -> (SQUARE -> [MULT if e[idx]])* -> FROMMONT -> FINISH -> IDLE. If in_e_len=0, TOMONT goes directly to FROMMONT.
- Each operation state has an issue phase and a wait phase:
  - Issue cycle: mont_start=1 for exactly one cycle, with mont_a/mont_b/mont_m already valid that cycle.
  - Operands are held stable until mont_done.
  - On the cycle mont_done=1, mont_result is captured and the state advances.
  - The next operation's issue cycle is the following cycle, so there is exactly one cycle between mont_done and the next mont_start.
- Operations:
  - TOMONT: a=X, b=R2; result stored as xt.
  - SQUARE: a=acc, b=acc; result -> acc.
  - MULT: a=acc, b=xt; result -> acc.
  - FROMMONT: a=acc, b=1; result -> result register.
- Index rules:
  - After SQUARE, go to MULT if e[idx]=1, otherwise finish the bit.
  - Finishing a bit: if idx=0, go to FROMMONT; otherwise decrement idx and go to SQUARE.
- FINISH: done=1 for one cycle, busy=1 that cycle; next cycle IDLE, busy=0.
- Total mont_start pulses = 2 + in_e_len + popcount(in_e[in_e_len-1:0]).
- Exponent bits at or above in_e_len are ignored.
- in_e_len=0 gives result 1 mod M.
- start while busy (including the FINISH cycle) is ignored.
- mont_done while not in a wait phase is ignored.
- mont_done in the same cycle as mont_start is not accepted; the multiplier latency is at least 1 cycle.

Decomposition:
- Shared package: state encoding localparams (IDLE, TOMONT, SQUARE, MULT, FROMMONT, FINISH), WIDTH default, LEN_W.
- No sub-module inside this block. The montgomery multiplier is instantiated beside it in rsa_top, which connects the mont_* ports.

Test Plan:
Bench setup: behavioural montgomery model returning a*b*R^-1 mod m after a programmable latency (default 5 cycles). Small-vector scenarios use WIDTH=8, M=241, R mod M=15, R^2 mod M=225.
- X=5, E=3, len=2 -> result=125; exactly 6 mont_start pulses; done pulses once; busy low the cycle after done.
- X=2, E=0xA, len=4 -> result=60; 8 pulses. Repeat with model latency 1 and 37: identical result; gap mont_done->mont_start is always 1 cycle.
- X=5, E=0xFF, len=0 -> result=1; 2 pulses. X=5, E=1, len=1 -> result=5; 4 pulses.
- Start pulse mid-run (X=7), plus a spurious mont_done with no operation outstanding -> ignored; original X=2, E=0xA completes with 60. Change in_x the cycle after accept -> result unaffected.
- resetn=0 during the 3rd operation -> all outputs 0 immediately; no done. New run X=5, E=3, len=2 after release -> 125.
- WIDTH=1024, E=0x10001, len=17, Python-generated X/M/R/R2 -> result matches the script's pow(X,E,M); 21 pulses.
